// File: rtl/bp_mem_responder_pkg.sv
// bp_mem_responder_pkg: message types, FSM states, header struct macro and width helpers
`ifndef BP_MEM_RESPONDER_PKG_SV
`define BP_MEM_RESPONDER_PKG_SV
`define BP_MEM_RESPONDER_DECLARE_HDR_S(aw) \
  typedef struct packed { \
    logic [2:0] size; \
    logic [aw-1:0] addr; \
    logic [3:0] msg_type; \
  } bp_mem_hdr_s
package bp_mem_responder_pkg;
  localparam int msg_type_width_lp = 4;
  localparam int size_width_lp = 3;
  typedef enum logic [3:0] {
    e_rd = 4'd0,
    e_wr = 4'd1,
    e_uc_rd = 4'd2,
    e_uc_wr = 4'd3
  } bp_mem_resp_msg_type_e;
  typedef enum logic [2:0] {e_init, e_idle, e_access, e_drain, e_resp} state_e;
  function automatic int msg_width(input int paddr_w, input int block_w);
    return msg_type_width_lp + size_width_lp + paddr_w + block_w;
  endfunction
endpackage
`endif

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port SRAM with byte write mask and one-cycle read latency
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int width_p = 64,
  parameter int els_p = 1024,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [width_p-1:0]       data_o
);
  logic [width_p-1:0] mem [els_p];
  // Byte-masked write, or registered read of the addressed word
  always_ff @(posedge clk_i) begin
    if (v_i && w_i)
      for (int i = 0; i < mask_width_lp; i++)
        if (write_mask_i[i]) mem[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
    if (v_i && !w_i) data_o <= mem[addr_i];
  end
endmodule

// File: rtl/bp_mem_responder.sv
// bp_mem_responder: one-at-a-time mem_cmd/mem_resp responder over a 1RW SRAM (option: BP_MEM_RESPONDER_ZERO_INIT_EN)
module bp_mem_responder
  import bp_mem_responder_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int block_width_p = 512,
  parameter int word_width_p = 64,
  parameter int els_p = 1024,
  localparam int msg_width_lp = msg_width(paddr_width_p, block_width_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [msg_width_lp-1:0] mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,
  output logic [msg_width_lp-1:0] mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_yumi_i
);
  localparam int beats_lp = block_width_p / word_width_p;
  localparam int off_width_lp = $clog2(beats_lp);
  localparam int beat_width_lp = off_width_lp + 1;
  localparam int idx_width_lp = $clog2(els_p);
  localparam int mask_width_lp = word_width_p / 8;
  localparam int hdr_width_lp = msg_width_lp - block_width_p;

  `BP_MEM_RESPONDER_DECLARE_HDR_S(paddr_width_p);

  state_e state, state_n;
  bp_mem_hdr_s hdr, cmd_hdr;
  logic [block_width_p-1:0] data, cmd_data, resp_data;
  logic [beat_width_lp-1:0] beat;
  logic [off_width_lp-1:0] cap_idx;
  logic [idx_width_lp-1:0] base_idx, sram_idx, init_idx;
  logic [word_width_p-1:0] sram_wdata, sram_rdata, beat_wdata;
  logic [mask_width_lp-1:0] sram_mask, small_mask;
  logic [2:0] off;
  logic is_block, is_write, cmd_write, full, last_beat, accept, capture, init, sram_v, sram_w;

  assign cmd_hdr = mem_cmd_i[hdr_width_lp-1:0];
  assign cmd_data = mem_cmd_i[hdr_width_lp +: block_width_p];
  assign cmd_write = cmd_hdr.msg_type == e_wr || cmd_hdr.msg_type == e_uc_wr;
  assign is_block = hdr.msg_type == e_rd || hdr.msg_type == e_wr;
  assign is_write = hdr.msg_type == e_wr || hdr.msg_type == e_uc_wr;
  assign full = is_block || hdr.size >= 3'd3;
  assign last_beat = beat == (is_block ? beat_width_lp'(beats_lp - 1) : '0);
  assign accept = state == e_idle && mem_cmd_v_i;
  assign capture = !is_write && (state == e_drain || (state == e_access && beat != '0));
  assign cap_idx = beat[off_width_lp-1:0] - 1'b1;

`ifdef BP_MEM_RESPONDER_ZERO_INIT_EN
  localparam state_e reset_state = e_init;
  assign init = state == e_init;
  // Zero-fill sweep pointer; every reset restarts it at word 0
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) init_idx <= '0;
    else if (init) init_idx <= init_idx + 1'b1;
`else
  localparam state_e reset_state = e_idle;
  assign init = 1'b0;
  assign init_idx = '0;
`endif

  assign base_idx = hdr.addr[3 +: idx_width_lp];
  assign off = hdr.addr[2:0];
  assign beat_wdata = data[beat[off_width_lp-1:0]*word_width_p +: word_width_p];
  assign small_mask = (mask_width_lp'(1) << (1 << hdr.size[1:0])) - mask_width_lp'(1);
  assign sram_idx = init ? init_idx
                  : is_block ? {base_idx[idx_width_lp-1:off_width_lp], beat[off_width_lp-1:0]} : base_idx;
  assign sram_wdata = init ? '0
                    : is_block ? beat_wdata
                    : full ? data[word_width_p-1:0] : data[word_width_p-1:0] << {off, 3'b000};
  assign sram_mask = (init || full) ? '1 : small_mask << off;
  assign resp_data = is_write ? '0 : data;
  assign mem_resp_o = state == e_resp ? {resp_data, hdr} : '0;

  // Next-state, handshake outputs and SRAM strobes
  always_comb begin
    state_n = state;
    mem_cmd_ready_o = state == e_idle && reset_n_i;
    mem_resp_v_o = state == e_resp;
    sram_v = init || state == e_access;
    sram_w = init || is_write;
    case (state)
      e_init:   state_n = init_idx == idx_width_lp'(els_p - 1) ? e_idle : e_init;
      e_idle:   state_n = mem_cmd_v_i ? e_access : e_idle;
      e_access: state_n = !last_beat ? e_access : is_write ? e_resp : e_drain;
      e_drain:  state_n = e_resp;
      e_resp:   state_n = mem_resp_yumi_i ? e_idle : e_resp;
      default:  state_n = reset_state;
    endcase
  end

  // State, latched command, beat counter and read-data assembly
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= reset_state;
      hdr <= '0;
      data <= '0;
      beat <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        hdr <= cmd_hdr;
        data <= cmd_write ? cmd_data : '0;
        beat <= '0;
      end else if (state == e_access) beat <= beat + 1'b1;
      if (capture) data[cap_idx*word_width_p +: word_width_p] <= sram_rdata;
    end

  bsg_mem_1rw_sync_mask_write_byte #(
    .width_p(word_width_p),
    .els_p(els_p)
  ) sram (
    .clk_i(clk_i),
    .v_i(sram_v),
    .w_i(sram_w),
    .addr_i(sram_idx),
    .data_i(sram_wdata),
    .write_mask_i(sram_mask),
    .data_o(sram_rdata)
  );
endmodule

// File: tb/tb_bp_mem_responder.sv
// tb_bp_mem_responder: vector table plus reset/backpressure sequences against a response scoreboard
module tb_bp_mem_responder;
  localparam int PA = 40;
  localparam int BW = 512;
  localparam int WW = 64;
`ifdef BP_MEM_RESPONDER_ZERO_INIT_EN
  localparam int ELS = 16;
`else
  localparam int ELS = 1024;
`endif
  localparam int MW = 4 + 3 + PA + BW;
  localparam int NV = 13;

  typedef struct {
    logic [3:0] t;
    logic [2:0] sz;
    logic [PA-1:0] a;
    logic [BW-1:0] d;
    logic [BW-1:0] e;
    int lat;
  } vec_t;

  logic clk = 0, reset_n = 0, cmd_v = 0, yumi = 0, cmd_ready, resp_v;
  logic [MW-1:0] cmd = '0, resp;
  int vectors = 0, miscompares = 0;
  logic [MW-1:0] exp_q[$];
  int lat_q[$];

  always #5 clk = ~clk;

  bp_mem_responder #(.paddr_width_p(PA), .block_width_p(BW), .word_width_p(WW), .els_p(ELS)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .mem_cmd_i(cmd),
    .mem_cmd_v_i(cmd_v),
    .mem_cmd_ready_o(cmd_ready),
    .mem_resp_o(resp),
    .mem_resp_v_o(resp_v),
    .mem_resp_yumi_i(yumi)
  );

  function automatic logic [BW-1:0] blk(input logic [31:0] base);
    for (int i = 0; i < BW / WW; i++) blk[i*WW +: WW] = 64'(base + 32'(i));
  endfunction

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [3:0] t, input logic [2:0] sz, input logic [PA-1:0] a,
                      input logic [BW-1:0] d, input logic [BW-1:0] e, input int lat, input bit track);
    int n = 0;
    cmd = {d, sz, a, t};
    cmd_v = 1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", MW'(cmd_ready), MW'(1));
    if (track) begin
      exp_q.push_back({e, sz, a, t});
      lat_q.push_back(lat);
    end
    @(negedge clk);
    cmd_v = 0;
  endtask

  task automatic collect(input string name, input int hold);
    int lat = 1;
    logic [MW-1:0] want = exp_q.pop_front();
    int want_lat = lat_q.pop_front();
    while (!resp_v && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, MW'(lat), MW'(want_lat));
    check({name, " resp"}, resp, want);
    if (!resp_v) return;
    for (int i = 0; i < hold; i++) begin
      cmd_v = 1;
      @(negedge clk);
      check({name, " hold v"}, MW'(resp_v), MW'(1));
      check({name, " hold ready"}, MW'(cmd_ready), MW'(0));
      check({name, " hold resp"}, resp, want);
    end
    yumi = 1;
    @(negedge clk);
    yumi = 0;
    if (hold > 0) check({name, " ready after yumi"}, MW'(cmd_ready), MW'(1));
    cmd_v = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl[NV];
    logic [BW-1:0] b0, b1, ba, bb, mix;
    int early, seen;
    b0 = blk(32'h1111_0000);
    b1 = b0;
    b1[127:64] = 64'hFFFF_FFFF;
    ba = blk(32'hAAAA_0000);
    bb = blk(32'hBBBB_0000);
    mix = ba;
    mix[255:0] = bb[255:0];
    tbl[0]  = '{4'd1, 3'd6, 40'h80, b0, '0, 9};
    tbl[1]  = '{4'd0, 3'd6, 40'h80, '0, b0, 10};
    tbl[2]  = '{4'd3, 3'd3, 40'h100, '0, '0, 2};
    tbl[3]  = '{4'd3, 3'd0, 40'h103, 512'h99AB, '0, 2};
    tbl[4]  = '{4'd2, 3'd3, 40'h100, '0, 512'hAB00_0000, 3};
    tbl[5]  = '{4'd3, 3'd3, 40'((ELS + 3) * 8), 512'h5A, '0, 2};
    tbl[6]  = '{4'd2, 3'd3, 40'h18, '0, 512'h5A, 3};
    tbl[7]  = '{4'd0, 3'd6, 40'h85, '0, b0, 10};
    tbl[8]  = '{4'd3, 3'd1, 40'h106, 512'hCDEF, '0, 2};
    tbl[9]  = '{4'd2, 3'd3, 40'h100, '0, 512'hCDEF_0000_AB00_0000, 3};
    tbl[10] = '{4'd5, 3'd3, 40'h100, blk(32'h7777_0000), 512'hCDEF_0000_AB00_0000, 3};
    tbl[11] = '{4'd3, 3'd2, 40'h88, 512'hDEAD_BEEF_FFFF_FFFF, '0, 2};
    tbl[12] = '{4'd0, 3'd6, 40'h80, '0, b1, 10};
    @(negedge clk);
    check("reset ready", MW'(cmd_ready), MW'(0));
    check("reset resp_v", MW'(resp_v), MW'(0));
    check("reset resp", resp, MW'(0));
    reset_n = 1;
`ifdef BP_MEM_RESPONDER_ZERO_INIT_EN
    early = 0;
    for (int n = 1; n < ELS; n++) begin
      @(negedge clk);
      early += int'(cmd_ready);
    end
    check("init ready low", MW'(early), MW'(0));
    @(negedge clk);
    check("init ready high", MW'(cmd_ready), MW'(1));
    send(4'd0, 3'd6, 40'h0, '0, '0, 10, 1);
    collect("init rd", 0);
`else
    @(negedge clk);
    check("idle ready", MW'(cmd_ready), MW'(1));
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].t, tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].lat, 1);
      collect($sformatf("vec%0d", i), 0);
    end
    send(4'd2, 3'd3, 40'h100, '0, 512'hCDEF_0000_AB00_0000, 3, 1);
    cmd = {512'h0, 3'd3, 40'h18, 4'd2};
    collect("backpressure", 20);
    send(4'd1, 3'd6, 40'hC0, ba, '0, 9, 1);
    collect("pre-reset wr", 0);
    send(4'd1, 3'd6, 40'hC0, bb, '0, 9, 0);
    repeat (4) @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("async ready", MW'(cmd_ready), MW'(0));
    check("async resp_v", MW'(resp_v), MW'(0));
    check("async resp", resp, MW'(0));
    repeat (2) @(negedge clk);
    reset_n = 1;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (n == 0) check("post-reset ready", MW'(cmd_ready), MW'(1));
      seen += int'(resp_v);
    end
    check("no resp after reset", MW'(seen), MW'(0));
    send(4'd0, 3'd6, 40'hC0, '0, mix, 10, 1);
    collect("partial block", 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
